uart_tx_serializer: RTL

UART transmitter stage sitting directly downstream of the baud-rate tick generator. It consumes the generator's single-cycle oversampling tick (s_tick) to time each serial bit. It accepts parallel bytes over a valid/ready handshake and serializes them LSB-first onto the tx line as start, data, optional parity and stop bits. Idle line is high.

---
 rtl/uart_tx_serializer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serializes a DBIT-wide word LSB-first as
// start, data, [parity], stop. Each bit is timed with s_tick pulses
// from the baud generator. The idle line is high.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit
// between the data and stop phases. The parity sense is set by
// PARITY_ODD: 0 selects even parity, 1 selects odd parity.
module uart_tx_serializer #(
   parameter int DBIT       = 8,
   parameter int OS         = 16,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic [DBIT-1:0] tx_data,
   input  logic            tx_valid,
   output logic            tx_ready,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
   localparam int TW   = $clog2(TMAX);
   localparam int BW   = $clog2(DBIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state_q;
   logic [TW-1:0]   tick_q;
   logic [BW-1:0]   bit_q;
   logic [DBIT-1:0] shift_q;
   logic            tx_q;
   logic            ready_q;
   logic            done_q;
`ifdef UART_TX_PARITY_EN
   // Parity is taken from the word at accept time, before any shifting.
   logic            parity_q;
`endif

   // Frame sequencer. All outputs are registered alongside the state.
   // NOTE: reset is asynchronous. State updates use non-blocking
   // assignments, so every register in this block samples the values
   // from the previous clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // An s_tick that arrives in the accept cycle is not counted.
               if (tx_valid) begin
                  shift_q  <= tx_data;
                  tick_q   <= '0;
                  tx_q     <= 1'b0;
                  ready_q  <= 1'b0;
                  state_q  <= START;
`ifdef UART_TX_PARITY_EN
                  parity_q <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
               end
            end
            START: begin
               if (s_tick) begin
                  if (tick_q == TW'(OS - 1)) begin
                     tick_q  <= '0;
                     bit_q   <= '0;
                     tx_q    <= shift_q[0];
                     state_q <= DATA;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (tick_q == TW'(OS - 1)) begin
                     tick_q  <= '0;
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + BW'(1);
                     if (bit_q == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_q    <= parity_q;
                        state_q <= PARITY;
`else
                        tx_q    <= 1'b1;
                        state_q <= STOP;
`endif
                     end else begin
                        tx_q <= shift_q[1];
                     end
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (tick_q == TW'(OS - 1)) begin
                     tick_q  <= '0;
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (tick_q == TW'(SB_TICK - 1)) begin
                     tick_q  <= '0;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_ready     = ready_q;
   assign tx_busy      = ~ready_q;
   assign tx           = tx_q;
   assign tx_done_tick = done_q;

endmodule
